// File: rtl/regs_wb_arbiter.sv
// Arbitrates two writeback sources onto the single regs write port (1-cycle registered write) and keeps the busy scoreboard.
// Backpressure: the losing requester sees rdy low and holds its request; i_ce low stalls every grant.
module regs_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_a_vld,
    output logic        o_a_rdy,
    input  logic [4:0]  i_a_addr,
    input  logic [31:0] i_a_dat,
    input  logic        i_b_vld,
    output logic        o_b_rdy,
    input  logic [4:0]  i_b_addr,
    input  logic [31:0] i_b_dat,
    input  logic        i_issue_vld,
    input  logic [4:0]  i_issue_rd,
    input  logic        i_flush,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic        o_hazard,
    output logic [31:0] o_busy,
    output logic        o_we,
    output logic [4:0]  o_addr_wr,
    output logic [31:0] o_dat_wr
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          active;
    logic          force_b;
    logic          xfer;
    logic [4:0]    win_addr;
    logic [31:0]   win_dat;
    logic [31:0]   clr_mask;
    logic [31:0]   set_mask;

    assign active  = i_ce && !i_rst;
    assign force_b = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

    // B wins a collision only once A has starved it for LIMIT grants in a row
    assign o_a_rdy = active && i_a_vld && !(i_b_vld && force_b);
    assign o_b_rdy = active && i_b_vld && (!i_a_vld || force_b);

    assign xfer     = o_a_rdy || o_b_rdy;
    assign win_addr = o_b_rdy ? i_b_addr : i_a_addr;
    assign win_dat  = o_b_rdy ? i_b_dat  : i_a_dat;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (xfer)
            clr_mask[win_addr] = 1'b1;
        if (i_issue_vld && (i_issue_rd != 5'd0))
            set_mask[i_issue_rd] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (i_ce) begin
            if (o_b_rdy || !i_b_vld)
                starve_cnt <= '0;
            else if (o_a_rdy && (starve_cnt != LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_we      <= 1'b0;
            o_addr_wr <= '0;
            o_dat_wr  <= '0;
        end else if (i_ce) begin
            o_we <= xfer && (win_addr != 5'd0);
            if (xfer) begin
                o_addr_wr <= win_addr;
                o_dat_wr  <= win_dat;
            end
        end else begin
            o_we <= 1'b0;
        end
    end

    // Set after clear: a newly issued producer outranks the retiring one
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_busy <= '0;
        end else if (i_ce) begin
            if (i_flush)
                o_busy <= '0;
            else
                o_busy <= ((o_busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
        end
    end

    assign o_hazard = ((i_rs1 != 5'd0) && o_busy[i_rs1]) ||
                      ((i_rs2 != 5'd0) && o_busy[i_rs2]);

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter: main instance with STARVE_LIMIT=4, second with pure fixed priority.
module tb_regs_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst, ce;
    logic        a_vld, b_vld, issue_vld, flush;
    logic [4:0]  a_addr, b_addr, issue_rd, rs1, rs2;
    logic [31:0] a_dat, b_dat;

    logic        a_rdy, b_rdy, hazard, we;
    logic [31:0] busy, dat_wr;
    logic [4:0]  addr_wr;

    logic        z_a_rdy, z_b_rdy, z_hazard, z_we;
    logic [31:0] z_busy, z_dat_wr;
    logic [4:0]  z_addr_wr;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regs_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce),
        .i_a_vld(a_vld), .o_a_rdy(a_rdy), .i_a_addr(a_addr), .i_a_dat(a_dat),
        .i_b_vld(b_vld), .o_b_rdy(b_rdy), .i_b_addr(b_addr), .i_b_dat(b_dat),
        .i_issue_vld(issue_vld), .i_issue_rd(issue_rd), .i_flush(flush),
        .i_rs1(rs1), .i_rs2(rs2), .o_hazard(hazard), .o_busy(busy),
        .o_we(we), .o_addr_wr(addr_wr), .o_dat_wr(dat_wr)
    );

    regs_wb_arbiter #(.STARVE_LIMIT(0)) dut_fixed (
        .i_clk(clk), .i_rst(rst), .i_ce(ce),
        .i_a_vld(a_vld), .o_a_rdy(z_a_rdy), .i_a_addr(a_addr), .i_a_dat(a_dat),
        .i_b_vld(b_vld), .o_b_rdy(z_b_rdy), .i_b_addr(b_addr), .i_b_dat(b_dat),
        .i_issue_vld(issue_vld), .i_issue_rd(issue_rd), .i_flush(flush),
        .i_rs1(rs1), .i_rs2(rs2), .o_hazard(z_hazard), .o_busy(z_busy),
        .o_we(z_we), .o_addr_wr(z_addr_wr), .o_dat_wr(z_dat_wr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_vld = 0; b_vld = 0; issue_vld = 0; flush = 0;
        a_addr = 0; b_addr = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        a_dat = 0; b_dat = 0;
    endtask

    task automatic test_reset();
        rst = 1; ce = 1; idle_inputs();
        a_vld = 1; a_addr = 5'd3; a_dat = 32'h1111;
        #1;
        compared++;
        if (a_rdy !== 1'b0) begin
            mismatched++; $display("FAIL reset_a_rdy: got %b want 0", a_rdy);
        end
        tick(); tick();
        compared++;
        if ({we, addr_wr, dat_wr, busy} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
            mismatched++;
            $display("FAIL reset_outputs: got we=%b addr=%0d dat=%h busy=%h want all zero", we, addr_wr, dat_wr, busy);
        end
        rst = 0; idle_inputs();
        tick();
    endtask

    task automatic test_single_write();
        a_vld = 1; a_addr = 5'd5; a_dat = 32'hDEADBEEF;
        #1;
        compared++;
        if ({a_rdy, b_rdy} !== 2'b10) begin
            mismatched++; $display("FAIL single_grant: got a=%b b=%b want a=1 b=0", a_rdy, b_rdy);
        end
        tick();
        a_vld = 0;
        compared++;
        if ({we, addr_wr, dat_wr} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            mismatched++;
            $display("FAIL single_write: got we=%b addr=%0d dat=%h want we=1 addr=5 dat=deadbeef", we, addr_wr, dat_wr);
        end
        tick();
        compared++;
        if ({we, addr_wr, dat_wr} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            mismatched++;
            $display("FAIL single_idle_hold: got we=%b addr=%0d dat=%h want we=0 addr=5 dat=deadbeef", we, addr_wr, dat_wr);
        end
    endtask

    task automatic test_starvation();
        logic exp_b;
        a_vld = 1; a_addr = 5'd1; a_dat = 32'hA;
        b_vld = 1; b_addr = 5'd2; b_dat = 32'hB;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_b = (i % 5 == 4);
            compared++;
            if ({a_rdy, b_rdy} !== {~exp_b, exp_b}) begin
                mismatched++;
                $display("FAIL starve_pattern[%0d]: got a=%b b=%b want a=%b b=%b", i, a_rdy, b_rdy, ~exp_b, exp_b);
            end
            compared++;
            if ({z_a_rdy, z_b_rdy} !== 2'b10) begin
                mismatched++;
                $display("FAIL fixed_priority[%0d]: got a=%b b=%b want a=1 b=0", i, z_a_rdy, z_b_rdy);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard();
        issue_vld = 1; issue_rd = 5'd7;
        tick();
        issue_vld = 0; rs1 = 5'd7;
        #1;
        compared++;
        if ({busy[7], hazard} !== 2'b11) begin
            mismatched++; $display("FAIL hazard_set: got busy7=%b hazard=%b want 1 1", busy[7], hazard);
        end
        rs1 = 5'd0; rs2 = 5'd7;
        #1;
        compared++;
        if (hazard !== 1'b1) begin
            mismatched++; $display("FAIL hazard_rs2: got %b want 1", hazard);
        end
        rs1 = 5'd7; rs2 = 5'd0;
        b_vld = 1; b_addr = 5'd7; b_dat = 32'h77;
        #1;
        compared++;
        if ({b_rdy, hazard} !== 2'b11) begin
            mismatched++; $display("FAIL hazard_b_grant: got b_rdy=%b hazard=%b want 1 1", b_rdy, hazard);
        end
        tick();
        b_vld = 0;
        #1;
        compared++;
        if ({busy[7], hazard, we, addr_wr, dat_wr} !== {1'b0, 1'b0, 1'b1, 5'd7, 32'h77}) begin
            mismatched++;
            $display("FAIL hazard_clear: got busy7=%b hazard=%b we=%b addr=%0d dat=%h want 0 0 1 7 77",
                     busy[7], hazard, we, addr_wr, dat_wr);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_x0();
        a_vld = 1; a_addr = 5'd0; a_dat = 32'h1234;
        issue_vld = 1; issue_rd = 5'd0;
        #1;
        compared++;
        if (a_rdy !== 1'b1) begin
            mismatched++; $display("FAIL x0_grant: got %b want 1", a_rdy);
        end
        tick();
        idle_inputs();
        compared++;
        if ({we, busy} !== {1'b0, 32'd0}) begin
            mismatched++; $display("FAIL x0_write: got we=%b busy=%h want we=0 busy=0", we, busy);
        end
    endtask

    task automatic test_same_cycle();
        a_vld = 1; a_addr = 5'd9; a_dat = 32'h99;
        issue_vld = 1; issue_rd = 5'd9;
        tick();
        idle_inputs();
        compared++;
        if ({busy, we, addr_wr} !== {32'h0000_0200, 1'b1, 5'd9}) begin
            mismatched++; $display("FAIL set_wins: got busy=%h we=%b addr=%0d want busy=00000200 we=1 addr=9", busy, we, addr_wr);
        end
    endtask

    task automatic test_flush();
        issue_vld = 1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        tick();
        issue_vld = 0;
        compared++;
        if (busy !== 32'h0000_0218) begin
            mismatched++; $display("FAIL flush_pre: got busy=%h want 00000218", busy);
        end
        flush = 1; issue_vld = 1; issue_rd = 5'd3;
        tick();
        idle_inputs();
        compared++;
        if (busy !== 32'd0) begin
            mismatched++; $display("FAIL flush_clear: got busy=%h want 0", busy);
        end
    endtask

    task automatic test_clock_enable();
        issue_vld = 1; issue_rd = 5'd6;
        tick();
        ce = 0; issue_rd = 5'd8;
        a_vld = 1; a_addr = 5'd6; a_dat = 32'h66;
        #1;
        compared++;
        if (a_rdy !== 1'b0) begin
            mismatched++; $display("FAIL ce_grant: got %b want 0", a_rdy);
        end
        tick();
        compared++;
        if ({we, addr_wr, busy} !== {1'b0, 5'd9, 32'h0000_0040}) begin
            mismatched++; $display("FAIL ce_hold: got we=%b addr=%0d busy=%h want we=0 addr=9 busy=00000040", we, addr_wr, busy);
        end
        ce = 1; issue_vld = 0;
        tick();
        a_vld = 0;
        compared++;
        if ({we, addr_wr, dat_wr, busy} !== {1'b1, 5'd6, 32'h66, 32'd0}) begin
            mismatched++;
            $display("FAIL ce_resume: got we=%b addr=%0d dat=%h busy=%h want 1 6 66 0", we, addr_wr, dat_wr, busy);
        end
        tick();
    endtask

    task automatic test_midstream_reset();
        issue_vld = 1; issue_rd = 5'd10;
        a_vld = 1; a_addr = 5'd11; a_dat = 32'hBB;
        tick();
        issue_vld = 0; rs1 = 5'd10;
        rst = 1; b_vld = 1; b_addr = 5'd12;
        #1;
        compared++;
        if ({we, busy[10], hazard, a_rdy, b_rdy} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL rst_pre: got we=%b busy10=%b hazard=%b a=%b b=%b want 1 1 1 0 0",
                     we, busy[10], hazard, a_rdy, b_rdy);
        end
        tick();
        compared++;
        if ({we, addr_wr, dat_wr, busy, hazard} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0}) begin
            mismatched++;
            $display("FAIL rst_mid: got we=%b addr=%0d dat=%h busy=%h hazard=%b want all zero",
                     we, addr_wr, dat_wr, busy, hazard);
        end
        rst = 0; idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_starvation();
        test_hazard();
        test_x0();
        test_same_cycle();
        test_flush();
        test_clock_enable();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
